// File: rtl/bmp_ram_reader_pkg.sv
// Shared widths, state encoding and buffer payload for the BMP RAM reader.
package bmp_ram_reader_pkg;

  localparam int unsigned ADDR_WIDTH     = 32;
  localparam int unsigned BYTE_WIDTH     = 8;
  localparam int unsigned BMP_TOTAL_SIZE = 786486;
  localparam int unsigned FIFO_DEPTH     = 2;
  localparam int unsigned CNT_WIDTH      = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef struct packed {
    logic                  last;
    logic [BYTE_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/bmp_byte_fifo.sv
// Two-entry synchronous FIFO holding returned RAM bytes plus their last flag.
module bmp_byte_fifo
  import bmp_ram_reader_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_push,
  input  fifo_entry_t          i_wr_entry,
  input  logic                 i_pop,
  output fifo_entry_t          o_rd_entry,
  output logic                 o_full,
  output logic                 o_empty,
  output logic [CNT_WIDTH-1:0] o_count
);

  fifo_entry_t          r_mem [FIFO_DEPTH];
  logic                 r_wr_ptr;
  logic                 r_rd_ptr;
  logic [CNT_WIDTH-1:0] r_count;
  logic                 w_do_pop;
  logic                 w_do_push;

  assign o_full     = (r_count == CNT_WIDTH'(FIFO_DEPTH));
  assign o_empty    = (r_count == '0);
  assign o_count    = r_count;
  assign o_rd_entry = r_mem[r_rd_ptr];

  // A push into a full buffer is only taken when a pop frees a slot in the same cycle.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= i_wr_entry;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_do_pop) r_rd_ptr <= ~r_rd_ptr;
      r_count <= r_count + CNT_WIDTH'(w_do_push) - CNT_WIDTH'(w_do_pop);
    end
  end

endmodule

// File: rtl/bmp_ram_reader.sv
// Streams a contiguous byte range of the image RAM out as a valid/ready byte stream.
module bmp_ram_reader
  import bmp_ram_reader_pkg::*;
#(
  parameter int unsigned TOTAL_SIZE = BMP_TOTAL_SIZE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH-1:0] len,
  output logic                  busy,
  output logic                  done,
  output logic                  RAM_rd_en,
  output logic [ADDR_WIDTH-1:0] RAM_addr,
  input  logic [BYTE_WIDTH-1:0] RAM_Q,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BYTE_WIDTH-1:0] out_data,
  output logic                  out_last
);

  state_t                r_state;
  state_t                w_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [ADDR_WIDTH-1:0] r_eff_len;
  logic [ADDR_WIDTH-1:0] r_issued;
  logic [ADDR_WIDTH-1:0] r_returned;
  logic                  r_inflight;
  logic                  w_rd_en;
  logic                  w_pop;
  logic                  w_room;
  logic                  w_full;
  logic                  w_empty;
  logic [CNT_WIDTH-1:0]  w_count;
  fifo_entry_t           w_wr_entry;
  fifo_entry_t           w_rd_entry;

  assign w_pop  = !w_empty && out_ready;
  // Buffered + in-flight bytes, less the one leaving now, must stay below the buffer depth.
  assign w_room = (3'({1'b0, w_count}) + 3'(r_inflight)) < (3'(FIFO_DEPTH) + 3'(w_pop));

  assign w_wr_entry.data = RAM_Q;
  assign w_wr_entry.last = (r_returned == r_eff_len - ADDR_WIDTH'(1));

  always_comb begin
    w_next  = r_state;
    w_rd_en = 1'b0;
    case (r_state)
      IDLE:  if (start) w_next = READ;
      READ: begin
        w_rd_en = (r_issued < r_eff_len) && w_room;
        if (w_rd_en && (r_issued == r_eff_len - ADDR_WIDTH'(1))) w_next = DRAIN;
      end
      DRAIN: if (w_pop && w_rd_entry.last) w_next = DONE;
      DONE:  w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_addr     <= '0;
      r_eff_len  <= '0;
      r_issued   <= '0;
      r_returned <= '0;
      r_inflight <= 1'b0;
    end else begin
      r_state    <= w_next;
      r_inflight <= w_rd_en;
      if (r_state == IDLE && start) begin
        r_addr     <= base_addr;
        r_eff_len  <= (len == '0) ? ADDR_WIDTH'(TOTAL_SIZE) : len;
        r_issued   <= '0;
        r_returned <= '0;
      end
      if (w_rd_en) begin
        r_addr   <= r_addr + ADDR_WIDTH'(1);
        r_issued <= r_issued + ADDR_WIDTH'(1);
      end
      if (r_inflight) r_returned <= r_returned + ADDR_WIDTH'(1);
    end
  end

  // Issue throttling guarantees a returning byte always finds a free slot.
  always_ff @(posedge clk) begin
    if (!rst) assert (!(r_inflight && w_full && !w_pop));
  end

  bmp_byte_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (r_inflight),
    .i_wr_entry (w_wr_entry),
    .i_pop      (w_pop),
    .o_rd_entry (w_rd_entry),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_count    (w_count)
  );

  assign busy      = (r_state == READ) || (r_state == DRAIN);
  assign done      = (r_state == DONE);
  assign RAM_rd_en = w_rd_en;
  assign RAM_addr  = r_addr;
  assign out_valid = !w_empty;
  assign out_data  = w_rd_entry.data;
  assign out_last  = w_rd_entry.last && !w_empty;

endmodule
